prog_loader: RTL and testbench
==============================

# prog_loader

Serial program loader driving the RAM programming port of the 8-bit computer (`prog_mode`, `addr`, `data_in`). Receives a 16-byte program over a 3-wire SPI-style link (`cs_n`, `sclk`, `sdi`) and sequences each byte to its RAM address, holding it stable for a fixed number of cycles. Lets an external host reload the computer without toggling address and data pins by hand.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: `fastClk` cycles each address/data pair is held; legal range ≥1.
- `SYNC_STAGES`, default 2: synchronizer depth on `cs_n`, `sclk` and `sdi`; legal range ≥2.

Ports:
- `fastClk`  in  1  the single clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `cs_n`  in  1  transfer frame, active-low; asynchronous to `fastClk`.
- `sclk`  in  1  serial bit clock; `sdi` is sampled on its rising edge.
- `sdi`  in  1  serial data, MSB first.
- `prog_mode`  out  1  high while programming; drives the computer's `prog_mode`.
- `addr`  out  4  RAM programming address.
- `prog_data`  out  8  RAM programming data; connects to the computer's `data_in`.
- `busy`  out  1  high from frame start until completion or abort.
- `done`  out  1  single-cycle pulse when the load completes.
- `err`  out  1  sticky error flag; cleared on the next frame start.

## Operation
- The receive path synchronizes the three inputs. It detects rising `sclk` edges and `cs_n` falling and rising edges. Each `sclk` rising edge in a frame shifts in one bit. The 8th bit produces a byte-valid pulse and clears the bit count.
- The FSM has five states:
  - IDLE: all outputs at rest. On a `cs_n` fall, go to WAIT, set `busy=1` and `prog_mode=1`, clear `err`, and set the byte index to 0.
  - WAIT: on byte valid, latch `addr`=index and `prog_data`=byte, load the hold counter with `HOLD_CYCLES-1`, and go to WRITE.
  - WRITE: the hold counter decrements each cycle. At 0, the index increments. If the index was 15, go to DONE; otherwise return to WAIT.
  - DONE: `done=1` for one cycle; `prog_mode=0`, `busy=0`; go to IDLE. `addr` and `prog_data` keep their last values.
  - ABORT: `err=1`, `prog_mode=0`, `busy=0`, `addr=0`; go to IDLE.
- Byte index: 4-bit; 15 is the terminal value. Index wrap is not possible because DONE is taken at 15.
- Boundary conditions:
  - Overrun: a byte valid arriving in WRITE is dropped and `err=1`. The sequence continues with the next byte.
  - A `cs_n` rise before 16 bytes are written goes to ABORT. Any partial byte is discarded.
  - A `cs_n` rise after DONE, or while in IDLE, has no effect.
  - Bytes arriving in IDLE after completion are ignored until the next `cs_n` fall.
  - `sclk` edges while `cs_n` is high are ignored. The bit count resets on every `cs_n` fall.
  - A `cs_n` fall in WAIT or WRITE restarts the frame: index=0, `err` cleared.
- A reset assertion mid-load returns immediately to IDLE with all outputs at their reset values.

## Timing
- Reset values: `prog_mode`=0, `addr`=0, `prog_data`=0, `busy`=0, `done`=0, `err`=0. All receive-path state is cleared.
- Input latency: `SYNC_STAGES`+1 `fastClk` cycles from a pin edge to the internal edge pulse.
- `prog_mode` and `busy` rise 1 cycle after the internal `cs_n` fall pulse.
- `addr` and `prog_data` update 1 cycle after byte valid. They then stay stable for exactly `HOLD_CYCLES` cycles, and remain stable until the next update.
- The `done` pulse is emitted `HOLD_CYCLES`+1 cycles after the 16th byte valid.
- Host constraint: `sclk` high and low phases must each be ≥ `SYNC_STAGES`+1 cycles. Bytes must be spaced ≥ `HOLD_CYCLES`+2 cycles apart; closer spacing is an overrun.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - A 17th byte is expected after the 16 data bytes.
  - While in WAIT for it, `prog_mode` stays high.
  - If the byte equals the 8-bit wrap-around sum of the 16 data bytes, go to DONE. Otherwise set `err=1` and go to DONE without a `done` pulse.
  - A `cs_n` rise before the checksum arrives goes to ABORT.
- Not defined: DONE follows the 16th write directly, and no checksum logic is generated.

## Structure
- Shared package `eight_bit_pkg`:
  - `RAM_DEPTH`=16, `WORD_W`=8, `ADDR_W`=4.
  - The loader state enum (IDLE, WAIT, WRITE, DONE, ABORT).
- One sub-module, `spi_byte_rx`. It contains the synchronizers, edge detection, shift register and bit counter. Its outputs are the byte, byte valid, and the frame start and frame end pulses.

## Test plan
- Full load of bytes 0x10..0x1F, with `HOLD_CYCLES`=4:
  - `addr` steps 0..15 with `prog_data`=0x10+`addr`, each value held 4 cycles.
  - `done` pulses once; `prog_mode` falls with `done`; `err`=0.
- Load with 0xFF, 0x00 alternating, then sample the computer's RAM through its normal read path: contents match the pattern.
- `cs_n` rises after 5 bytes plus 3 bits:
  - ABORT: `err`=1, `prog_mode`=0, `addr`=0, no `done`.
  - A new frame then clears `err`.
- Two bytes sent 2 cycles apart while in WRITE: second byte dropped, `err`=1, subsequent bytes written to the next addresses.
- Reset asserted during byte 7 write: all outputs 0 in the same cycle. A full load after reset succeeds.
- With `PROG_LOADER_CHECKSUM_EN`:
  - Bytes 0x01 ×16 with checksum 0x10: `done` pulses.
  - The same bytes with checksum 0x11: `err`=1 and no `done`.

Source files
------------

// File: rtl/eight_bit_pkg.sv
// Shared types and sizes for the 8-bit computer and its serial program loader.
// Optional checksum stage of the loader is enabled by PROG_LOADER_CHECKSUM_EN.
package eight_bit_pkg;

    localparam int unsigned RAM_DEPTH = 16;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WRITE,
        DONE,
        ABORT
    } loader_state_e;

    // One RAM programming beat: address plus data word.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } prog_word_t;

    function automatic logic [WORD_W-1:0] sum8(input logic [WORD_W-1:0] acc,
                                               input logic [WORD_W-1:0] val);
        return acc + val;
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI-style byte receiver: synchronizes cs_n/sclk/sdi, detects edges and
// assembles MSB-first bytes, emitting byte-valid and frame start/end pulses.
module spi_byte_rx
    import eight_bit_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              sdi,
    output logic [WORD_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              frame_start,
    output logic              frame_end
);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   cs_last;
    logic                   sclk_last;
    logic                   sdi_last;
    logic                   cs_prev;
    logic                   sclk_prev;
    logic                   sclk_rise;
    logic                   sdi_q;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [WORD_W-1:0]      shift_q;

    assign cs_last   = cs_sync[SYNC_STAGES-1];
    assign sclk_last = sclk_sync[SYNC_STAGES-1];
    assign sdi_last  = sdi_sync[SYNC_STAGES-1];
    assign rx_byte   = shift_q;

    // Synchronizer chains; cs_n rests high so reset does not fake a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            sdi_sync  <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
        end
    end

    // Registered edge pulses; sdi is delayed alongside so it lines up with sclk_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev     <= 1'b1;
            sclk_prev   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            sclk_rise   <= 1'b0;
            sdi_q       <= 1'b0;
        end else begin
            cs_prev     <= cs_last;
            sclk_prev   <= sclk_last;
            frame_start <= cs_prev & ~cs_last;
            frame_end   <= ~cs_prev & cs_last;
            sclk_rise   <= sclk_last & ~sclk_prev & ~cs_last;
            sdi_q       <= sdi_last;
        end
    end

    // Frame boundaries drop any partial byte; the counter wraps to 0 on the 8th bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (frame_start || frame_end) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_q <= {shift_q[WORD_W-2:0], sdi_q};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                if (bit_cnt == BIT_CNT_W'(WORD_W - 1)) begin
                    byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: writes 16 received bytes to consecutive RAM addresses
// through the programming port. PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module prog_loader
    import eight_bit_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              fastClk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              sdi,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] prog_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [WORD_W-1:0] rx_byte;
    logic              byte_valid;
    logic              frame_start;
    logic              frame_end;

    loader_state_e     state;
    logic [ADDR_W-1:0] idx;
    logic [HOLD_W-1:0] hold_cnt;
    prog_word_t        word_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum;
    logic              csum_phase;
`endif

    spi_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk        (fastClk),
        .rst_n      (rst),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .sdi        (sdi),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end)
    );

    assign addr      = word_q.addr;
    assign prog_data = word_q.data;

    // Loader sequencer; outputs change on the transition that enters each state.
    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            hold_cnt  <= '0;
            word_q    <= '0;
            prog_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (frame_start) begin
                // A new frame restarts from address 0 regardless of where we were.
                state     <= WAIT;
                idx       <= '0;
                prog_mode <= 1'b1;
                busy      <= 1'b1;
                err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum       <= '0;
                csum_phase <= 1'b0;
`endif
            end else if (frame_end && (state == WAIT || state == WRITE)) begin
                state       <= ABORT;
                err         <= 1'b1;
                prog_mode   <= 1'b0;
                busy        <= 1'b0;
                word_q.addr <= '0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    WAIT: begin
                        if (byte_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            if (csum_phase) begin
                                state     <= DONE;
                                prog_mode <= 1'b0;
                                busy      <= 1'b0;
                                if (rx_byte == csum) begin
                                    done <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end else begin
                                csum     <= sum8(csum, rx_byte);
                                word_q   <= '{addr: idx, data: rx_byte};
                                hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                                state    <= WRITE;
                            end
`else
                            word_q   <= '{addr: idx, data: rx_byte};
                            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                            state    <= WRITE;
`endif
                        end
                    end
                    WRITE: begin
                        // A byte landing mid-hold is an overrun: flag it and keep going.
                        if (byte_valid) begin
                            err <= 1'b1;
                        end
                        if (hold_cnt == '0) begin
                            idx <= idx + ADDR_W'(1);
                            if (idx == ADDR_W'(RAM_DEPTH - 1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                csum_phase <= 1'b1;
                                state      <= WAIT;
`else
                                state     <= DONE;
                                done      <= 1'b1;
                                prog_mode <= 1'b0;
                                busy      <= 1'b0;
`endif
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    ABORT:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (short and long hold) share one serial link
// and are checked every cycle against a protocol-level model plus directed literals.
module tb_prog_loader;

    localparam int H0 = 4;
    localparam int H1 = 100;
    localparam int S  = 2;
    localparam int PH_IDLE  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_WRITE = 2;

    logic fastClk = 1'b0;
    logic rst;
    logic cs_n;
    logic sclk;
    logic sdi;

    logic       prog_mode_w [2];
    logic [3:0] addr_w      [2];
    logic [7:0] prog_data_w [2];
    logic       busy_w      [2];
    logic       done_w      [2];
    logic       err_w       [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 fastClk = ~fastClk;

    prog_loader #(.HOLD_CYCLES(H0), .SYNC_STAGES(S)) u_dut0 (
        .fastClk(fastClk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .sdi(sdi),
        .prog_mode(prog_mode_w[0]), .addr(addr_w[0]), .prog_data(prog_data_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
    );

    prog_loader #(.HOLD_CYCLES(H1), .SYNC_STAGES(S)) u_dut1 (
        .fastClk(fastClk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .sdi(sdi),
        .prog_mode(prog_mode_w[1]), .addr(addr_w[1]), .prog_data(prog_data_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
    );

    // Model: pin history seen through the synchronizer latency, then loader rules.
    logic       hcs   [8];
    logic       hsclk [8];
    logic       hsdi  [8];
    int         rx_bits;
    logic [7:0] rx_val;
    bit         byte_pend;
    logic [7:0] byte_pend_val;

    int         m_phase [2];
    int         m_idx   [2];
    int         m_left  [2];
    logic [7:0] m_sum   [2];
    bit         m_ckph  [2];
    logic       m_pm    [2];
    logic       m_busy  [2];
    logic       m_done  [2];
    logic       m_err   [2];
    logic [3:0] m_addr  [2];
    logic [7:0] m_data  [2];

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            hcs[k] = 1'b1; hsclk[k] = 1'b0; hsdi[k] = 1'b0;
        end
        rx_bits = 0; rx_val = 8'h00; byte_pend = 1'b0; byte_pend_val = 8'h00;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = PH_IDLE; m_idx[i] = 0; m_left[i] = 0; m_sum[i] = 8'h00;
            m_ckph[i] = 1'b0; m_pm[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
            m_err[i] = 1'b0; m_addr[i] = 4'h0; m_data[i] = 8'h00;
        end
    endtask

    task automatic loader_step(input int i, input bit cf, input bit cr, input bit bev,
                               input logic [7:0] bval);
        int h;
        h = (i == 0) ? H0 : H1;
        m_done[i] = 1'b0;
        if (cf) begin
            m_phase[i] = PH_WAIT; m_idx[i] = 0; m_sum[i] = 8'h00; m_ckph[i] = 1'b0;
            m_pm[i] = 1'b1; m_busy[i] = 1'b1; m_err[i] = 1'b0;
        end else if (cr && m_phase[i] != PH_IDLE) begin
            m_phase[i] = PH_IDLE; m_err[i] = 1'b1; m_pm[i] = 1'b0; m_busy[i] = 1'b0;
            m_addr[i] = 4'h0;
        end else if (m_phase[i] == PH_WAIT && bev) begin
            if (m_ckph[i]) begin
                m_phase[i] = PH_IDLE; m_pm[i] = 1'b0; m_busy[i] = 1'b0;
                if (bval == m_sum[i]) m_done[i] = 1'b1;
                else m_err[i] = 1'b1;
            end else begin
                m_addr[i] = 4'(m_idx[i]); m_data[i] = bval;
                m_sum[i] = m_sum[i] + bval;
                m_left[i] = h; m_phase[i] = PH_WRITE;
            end
        end else if (m_phase[i] == PH_WRITE) begin
            if (bev) m_err[i] = 1'b1;
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
                if (m_idx[i] == 15) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    m_ckph[i] = 1'b1; m_phase[i] = PH_WAIT;
`else
                    m_phase[i] = PH_IDLE; m_done[i] = 1'b1; m_pm[i] = 1'b0; m_busy[i] = 1'b0;
`endif
                end else begin
                    m_phase[i] = PH_WAIT;
                end
                m_idx[i] = m_idx[i] + 1;
            end
        end
    endtask

    always @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            bit cf, cr, sr, bev;
            logic [7:0] bval;
            for (int k = 7; k > 0; k--) begin
                hcs[k] = hcs[k-1]; hsclk[k] = hsclk[k-1]; hsdi[k] = hsdi[k-1];
            end
            hcs[0] = cs_n; hsclk[0] = sclk; hsdi[0] = sdi;
            cf = hcs[S+2] && !hcs[S+1];
            cr = !hcs[S+2] && hcs[S+1];
            sr = !hsclk[S+2] && hsclk[S+1] && !hcs[S+1];
            bev = byte_pend; bval = byte_pend_val; byte_pend = 1'b0;
            if (cf || cr) begin
                rx_bits = 0;
            end else if (sr) begin
                rx_val = {rx_val[6:0], hsdi[S+1]};
                rx_bits = rx_bits + 1;
                if (rx_bits == 8) begin
                    rx_bits = 0; byte_pend = 1'b1; byte_pend_val = rx_val;
                end
            end
            for (int i = 0; i < 2; i++) loader_step(i, cf, cr, bev, bval);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge fastClk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [15:0] act, exp;
                act = {prog_mode_w[i], busy_w[i], done_w[i], err_w[i], addr_w[i], prog_data_w[i]};
                exp = {m_pm[i], m_busy[i], m_done[i], m_err[i], m_addr[i], m_data[i]};
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL cycle_model dut%0d t=%0t {pm,busy,done,err,addr,data} got %h expected %h",
                             i, $time, act, exp);
                end
            end
        end
    end

    // Stand-in for the computer's RAM, written through the programming port.
    logic [7:0] ram [16];
    int done_cnt;
    always @(negedge fastClk) begin
        if (prog_mode_w[0] === 1'b1) ram[addr_w[0]] = prog_data_w[0];
        if (done_w[0] === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge fastClk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int k = 7; k > 7 - nbits; k--) begin
            sdi = b[k];
            clk_n(4);
            sclk = 1'b1;
            clk_n(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        clk_n(6);
    endtask

    task automatic frame_finish();
        clk_n(H0 + 12);
        cs_n = 1'b1;
        clk_n(12);
    endtask

    logic [7:0] pgm [16];

    task automatic send_program();
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        for (int j = 0; j < 16; j++) s = s + pgm[j];
`endif
        for (int j = 0; j < 16; j++) ram[j] = 8'h55;
        done_cnt = 0;
        frame_begin();
        for (int j = 0; j < 16; j++) send_bits(pgm[j], 8);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_bits(s, 8);
`endif
        frame_finish();
    endtask

    task automatic check_ram(input string name);
        for (int j = 0; j < 16; j++) check(name, {24'h0, ram[j]}, {24'h0, pgm[j]});
    endtask

    initial begin
        rst = 1'b0; cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0;
        done_cnt = 0;
        clk_n(3);
        chk_en = 1'b1;
        check("reset_prog_mode", 32'(prog_mode_w[0]), 32'h0);
        check("reset_addr", 32'(addr_w[0]), 32'h0);
        check("reset_data", 32'(prog_data_w[0]), 32'h0);
        check("reset_busy", 32'(busy_w[0]), 32'h0);
        check("reset_err", 32'(err_w[1]), 32'h0);
        rst = 1'b1;
        clk_n(4);

        // Full load 0x10..0x1F.
        for (int j = 0; j < 16; j++) pgm[j] = 8'(8'h10 + j);
        send_program();
        check("load1_done_count", done_cnt, 1);
        check("load1_prog_mode", 32'(prog_mode_w[0]), 32'h0);
        check("load1_err", 32'(err_w[0]), 32'h0);
        check("load1_last_addr", 32'(addr_w[0]), 32'hF);
        check("load1_last_data", 32'(prog_data_w[0]), 32'h1F);
        check_ram("load1_ram");

        // Alternating 0xFF / 0x00.
        for (int j = 0; j < 16; j++) pgm[j] = (j % 2 == 0) ? 8'hFF : 8'h00;
        send_program();
        check("load2_done_count", done_cnt, 1);
        check_ram("load2_ram");

        // Abort after 5 bytes plus 3 bits.
        done_cnt = 0;
        frame_begin();
        check("frame_busy", 32'(busy_w[0]), 32'h1);
        check("frame_prog_mode", 32'(prog_mode_w[0]), 32'h1);
        for (int j = 0; j < 5; j++) send_bits(8'(8'h30 + j), 8);
        send_bits(8'hE0, 3);
        cs_n = 1'b1;
        clk_n(10);
        check("abort_err", 32'(err_w[0]), 32'h1);
        check("abort_prog_mode", 32'(prog_mode_w[0]), 32'h0);
        check("abort_addr", 32'(addr_w[0]), 32'h0);
        check("abort_busy", 32'(busy_w[0]), 32'h0);
        check("abort_done_count", done_cnt, 0);
        frame_begin();
        check("reframe_err_clear", 32'(err_w[0]), 32'h0);
        check("reframe_busy", 32'(busy_w[0]), 32'h1);
        cs_n = 1'b1;
        clk_n(12);

        // Overrun on the long-hold instance: second byte lands during its write.
        frame_begin();
        send_bits(8'hA1, 8);
        send_bits(8'hB2, 8);
        send_bits(8'hC3, 8);
        clk_n(10);
        check("ovr_err", 32'(err_w[1]), 32'h1);
        check("ovr_next_addr", 32'(addr_w[1]), 32'h1);
        check("ovr_next_data", 32'(prog_data_w[1]), 32'hC3);
        check("ovr_short_hold_addr", 32'(addr_w[0]), 32'h2);
        check("ovr_short_hold_err", 32'(err_w[0]), 32'h0);
        cs_n = 1'b1;
        clk_n(12);

        // Reset during the 7th byte's write.
        frame_begin();
        for (int j = 0; j < 7; j++) send_bits(8'(8'h40 + j), 8);
        clk_n(3);
        check("pre_reset_addr", 32'(addr_w[0]), 32'h6);
        #2;
        rst = 1'b0;
        #1;
        check("rst_prog_mode", 32'(prog_mode_w[0]), 32'h0);
        check("rst_addr", 32'(addr_w[0]), 32'h0);
        check("rst_data", 32'(prog_data_w[0]), 32'h0);
        check("rst_busy", 32'(busy_w[0]), 32'h0);
        check("rst_err", 32'(err_w[0]), 32'h0);
        check("rst_done", 32'(done_w[0]), 32'h0);
        cs_n = 1'b1;
        clk_n(3);
        rst = 1'b1;
        clk_n(5);
        for (int j = 0; j < 16; j++) pgm[j] = 8'(8'h10 + j);
        send_program();
        check("post_reset_done_count", done_cnt, 1);
        check("post_reset_err", 32'(err_w[0]), 32'h0);
        check_ram("post_reset_ram");

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum good (0x10) and bad (0x11) for sixteen 0x01 bytes.
        for (int c = 0; c < 2; c++) begin
            done_cnt = 0;
            frame_begin();
            for (int j = 0; j < 16; j++) send_bits(8'h01, 8);
            send_bits((c == 0) ? 8'h10 : 8'h11, 8);
            frame_finish();
            check("csum_done_count", done_cnt, (c == 0) ? 1 : 0);
            check("csum_err", 32'(err_w[0]), (c == 0) ? 32'h0 : 32'h1);
            check("csum_prog_mode", 32'(prog_mode_w[0]), 32'h0);
        end
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
